ldpc_enc_top: RTL

Systematic LDPC encoder for the (256,128) code whose codewords the osmlgd_top majority-logic decoder consumes. It accepts a 128-bit message and computes the 128 parity bits from a preloaded generator-parity array, processing P message bits per cycle. It outputs the 256-bit codeword with the same work/free/valid handshake as the decoder, so encoder output can drive decoder tx directly in loopback benches.

---
 rtl/ldpc_enc_top.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ldpc_enc_top.sv
// rtl/ldpc_enc_top.sv - systematic (N,K) LDPC encoder folding P message bits per cycle
//
// Ports:
//   clk      : system clock, all state changes on the rising edge
//   rst      : synchronous reset, active-high
//   work     : start strobe, accepted only while free=1
//   msg      : K-bit message, captured on the accepting edge
//   free     : 1 = idle and able to accept work
//   codeword : {message, parity}, held until the next completion or reset
//   valid    : one-cycle pulse marking codeword as new
//
// Garray holds the parity contribution of each message bit. It has no writer
// in this module; its contents are loaded from outside before use.
module ldpc_enc_top #(
  parameter int N = 256,
  parameter int K = 128,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         work,
  input  logic [K-1:0] msg,
  output logic         free,
  output logic [N-1:0] codeword,
  output logic         valid
);

  localparam int M     = N - K;
  localparam int STEPS = K / P;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int KW    = $clog2(K);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  logic [M-1:0] Garray [0:K-1];

  state_t         state_q, state_d;
  logic           free_q, free_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   codeword_q, codeword_d;
  logic [K-1:0]   msg_q, msg_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // XOR of the P generator rows selected by the current message slice
  logic [M-1:0]   fold;
  logic [KW-1:0]  idx;
  logic [M-1:0]   acc_next;

  always_comb begin
    fold = '0;
    idx  = '0;
    for (int j = 0; j < P; j++) begin
      idx = KW'(cnt_q) * KW'(P) + KW'(j);
      if (msg_q[idx]) fold = fold ^ Garray[idx];
    end
    acc_next = acc_q ^ fold;
  end

  always_comb begin
    state_d    = state_q;
    free_d     = free_q;
    valid_d    = valid_q;
    codeword_d = codeword_q;
    msg_d      = msg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (work) begin
          msg_d   = msg;
          acc_d   = '0;
          cnt_d   = '0;
          free_d  = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
        // last slice goes straight into the codeword, skipping a cycle
        if (cnt_q == CW'(STEPS - 1)) begin
          codeword_d = {msg_q, acc_next};
          valid_d    = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        valid_d = 1'b0;
        free_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        free_d  = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      free_q     <= 1'b1;
      valid_q    <= 1'b0;
      codeword_q <= '0;
      msg_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      free_q     <= free_d;
      valid_q    <= valid_d;
      codeword_q <= codeword_d;
      msg_q      <= msg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign free     = free_q;
  assign valid    = valid_q;
  assign codeword = codeword_q;

endmodule
